sar_adc_ctrl: RTL and testbench

SAR_ADC_CTRL -- requirements
Module: sar_adc_ctrl

---
 rtl/sar_pkg.sv | 27 ++
 rtl/sar_cmp_sync.sv | 34 +++
 rtl/sar_adc_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_sar_adc_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// -----------------------------------------------------------------------------
// sar_pkg
// Shared definitions for the SAR ADC controller slice:
//   - sar_state_e   : controller state encoding (IDLE, SAMPLE, CONVERT, DONE)
//   - DEF_*         : default parameter values for sar_adc_ctrl
//   - cnt_width()   : counter width for a phase of n cycles (never zero bits)
// -----------------------------------------------------------------------------
package sar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAMPLE  = 2'd1,
        ST_CONVERT = 2'd2,
        ST_DONE    = 2'd3
    } sar_state_e;

    localparam int DEF_WIDTH      = 32'd8;
    localparam int DEF_SAMPLE_CYC = 32'd4;
    localparam int DEF_SETTLE_CYC = 32'd2;

    // A phase of n cycles counts 0..n-1, which fits in clog2(n) bits;
    // a one-cycle phase still gets a 1-bit counter so no vector is zero-width.
    function automatic int cnt_width(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

endpackage

// File: rtl/sar_cmp_sync.sv
// -----------------------------------------------------------------------------
// sar_cmp_sync
// Two-flop synchronizer for the asynchronous analog comparator output.
// Both flops clear to 0 on reset.
// Ports:
//   clk      in  1  controller clock
//   rst      in  1  asynchronous active-high reset
//   cmp      in  1  raw comparator output
//   cmp_sync out 1  comparator output retimed into the clk domain
// -----------------------------------------------------------------------------
module sar_cmp_sync (
    input  logic clk,
    input  logic rst,
    input  logic cmp,
    output logic cmp_sync
);

    logic meta_r;
    logic sync_r;

    // Two-stage retiming chain; the first stage may go metastable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= cmp;
            sync_r <= meta_r;
        end
    end

    assign cmp_sync = sync_r;

endmodule

// File: rtl/sar_adc_ctrl.sv
// -----------------------------------------------------------------------------
// sar_adc_ctrl
// Successive-approximation ADC controller. A start in IDLE opens the sample
// switch for SAMPLE_CYC cycles, then resolves WIDTH bits MSB first, each trial
// code held on the DAC long enough to settle before the comparator decides the
// bit. The finished code is published with a one-cycle done pulse.
//
// Optional feature (macro SAR_CMP_SYNC_EN): the comparator passes through the
// sar_cmp_sync two-flop synchronizer and each bit is held two extra cycles so
// the decision still reflects the bit's own trial code.
//
// Parameters: WIDTH (2..12), SAMPLE_CYC (>=1), SETTLE_CYC (>=1)
// Ports:
//   clk      in  1      clock, all state changes on rising edge
//   rst      in  1      asynchronous active-high reset
//   start    in  1      conversion request, honoured in IDLE only
//   abort    in  1      cancel a conversion in SAMPLE or CONVERT
//   cmp      in  1      comparator, 1 means Vin >= Vdac
//   sample   out 1      sample switch closed
//   dac_code out WIDTH  trial code to the DAC
//   busy     out 1      controller not in IDLE
//   done     out 1      one-cycle pulse when result updates
//   result   out WIDTH  last completed conversion
//   valid    out 1      result is current (no newer start since)
// All outputs are registered and aligned with the state they belong to.
// -----------------------------------------------------------------------------
module sar_adc_ctrl
    import sar_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int SAMPLE_CYC = DEF_SAMPLE_CYC,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             cmp,
    output logic             sample,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             valid
);

`ifdef SAR_CMP_SYNC_EN
    localparam int HOLD_CYC = SETTLE_CYC + 32'sd2;
`else
    localparam int HOLD_CYC = SETTLE_CYC;
`endif

    localparam int SMP_W = cnt_width(SAMPLE_CYC);
    localparam int STL_W = cnt_width(HOLD_CYC);
    localparam int IDX_W = cnt_width(WIDTH);

    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(SAMPLE_CYC - 32'sd1);
    localparam logic [STL_W-1:0] STL_LAST = STL_W'(HOLD_CYC - 32'sd1);
    localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(WIDTH - 32'sd1);

    sar_state_e        state_r,   state_nxt_s;
    logic [SMP_W-1:0]  smp_cnt_r, smp_cnt_nxt_s;
    logic [STL_W-1:0]  stl_cnt_r, stl_cnt_nxt_s;
    logic [IDX_W-1:0]  bit_idx_r, bit_idx_nxt_s;
    logic [WIDTH-1:0]  code_r,    code_nxt_s;
    logic [WIDTH-1:0]  result_r,  result_nxt_s;
    logic              sample_r,  sample_nxt_s;
    logic              busy_r,    busy_nxt_s;
    logic              done_r,    done_nxt_s;
    logic              valid_r,   valid_nxt_s;
    logic [WIDTH-1:0]  kept_s;
    logic              cmp_dec_s;

`ifdef SAR_CMP_SYNC_EN
    sar_cmp_sync u_cmp_sync (
        .clk      (clk),
        .rst      (rst),
        .cmp      (cmp),
        .cmp_sync (cmp_dec_s)
    );
`else
    assign cmp_dec_s = cmp;
`endif

    // Next-state, counter, code and output decode.
    always_comb begin
        state_nxt_s   = state_r;
        smp_cnt_nxt_s = smp_cnt_r;
        stl_cnt_nxt_s = stl_cnt_r;
        bit_idx_nxt_s = bit_idx_r;
        code_nxt_s    = code_r;
        result_nxt_s  = result_r;
        sample_nxt_s  = 1'b0;
        done_nxt_s    = 1'b0;
        valid_nxt_s   = valid_r;

        // Current trial code with the bit under test replaced by the decision.
        kept_s             = code_r;
        kept_s[bit_idx_r]  = cmp_dec_s;

        case (state_r)
            ST_IDLE: begin
                // abort wins over a simultaneous start
                if (start && !abort) begin
                    state_nxt_s   = ST_SAMPLE;
                    smp_cnt_nxt_s = '0;
                    code_nxt_s    = '0;
                    sample_nxt_s  = 1'b1;
                    valid_nxt_s   = 1'b0;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end

            ST_SAMPLE: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                    code_nxt_s  = '0;
                    valid_nxt_s = 1'b0;
                end else if (smp_cnt_r == SMP_LAST) begin
                    state_nxt_s            = ST_CONVERT;
                    bit_idx_nxt_s          = IDX_MSB;
                    stl_cnt_nxt_s          = '0;
                    code_nxt_s             = '0;
                    code_nxt_s[WIDTH-1]    = 1'b1;
                end else begin
                    smp_cnt_nxt_s = smp_cnt_r + SMP_W'(1);
                    sample_nxt_s  = 1'b1;
                end
            end

            ST_CONVERT: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                    code_nxt_s  = '0;
                    valid_nxt_s = 1'b0;
                end else if (stl_cnt_r == STL_LAST) begin
                    if (bit_idx_r == '0) begin
                        state_nxt_s  = ST_DONE;
                        code_nxt_s   = '0;
                        result_nxt_s = kept_s;
                        done_nxt_s   = 1'b1;
                        valid_nxt_s  = 1'b1;
                    end else begin
                        // keep the decided bit, raise the next lower trial bit
                        bit_idx_nxt_s             = bit_idx_r - IDX_W'(1);
                        stl_cnt_nxt_s             = '0;
                        code_nxt_s                = kept_s;
                        code_nxt_s[bit_idx_nxt_s] = 1'b1;
                    end
                end else begin
                    stl_cnt_nxt_s = stl_cnt_r + STL_W'(1);
                end
            end

            ST_DONE: begin
                // start and abort are both ignored here
                state_nxt_s = ST_IDLE;
                code_nxt_s  = '0;
            end

            default: begin
                state_nxt_s = ST_IDLE;
                code_nxt_s  = '0;
                valid_nxt_s = 1'b0;
            end
        endcase

        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // State register with counters and bit pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            smp_cnt_r <= '0;
            stl_cnt_r <= '0;
            bit_idx_r <= '0;
        end else begin
            state_r   <= state_nxt_s;
            smp_cnt_r <= smp_cnt_nxt_s;
            stl_cnt_r <= stl_cnt_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
        end
    end

    // Registered outputs; the partial code is discarded on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_r   <= '0;
            result_r <= '0;
            sample_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            valid_r  <= 1'b0;
        end else begin
            code_r   <= code_nxt_s;
            result_r <= result_nxt_s;
            sample_r <= sample_nxt_s;
            busy_r   <= busy_nxt_s;
            done_r   <= done_nxt_s;
            valid_r  <= valid_nxt_s;
        end
    end

    assign sample   = sample_r;
    assign dac_code = code_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign result   = result_r;
    assign valid    = valid_r;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sar_adc_ctrl
// Self-checking bench for sar_adc_ctrl at default parameters. The comparator is
// modelled as an ideal analog compare (vin >= dac_code). Expected trial codes
// and results come from a plain binary-search reference model.
// -----------------------------------------------------------------------------
module tb_sar_adc_ctrl;

    localparam int W   = 8;
    localparam int SMP = 4;
    localparam int STL = 2;
`ifdef SAR_CMP_SYNC_EN
    localparam int HOLD = STL + 2;
`else
    localparam int HOLD = STL;
`endif
    localparam int LAT = SMP + W * HOLD + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         abort;
    logic         cmp;
    logic         sample;
    logic [W-1:0] dac_code;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         valid;
    logic [W-1:0] vin;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [W-1:0] exp_seq [W];
    logic [W-1:0] exp_res;
    logic [W-1:0] last_res;

    always #5 clk = ~clk;

    assign cmp = (vin >= dac_code);

    sar_adc_ctrl #(.WIDTH(W), .SAMPLE_CYC(SMP), .SETTLE_CYC(STL)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .cmp      (cmp),
        .sample   (sample),
        .dac_code (dac_code),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .valid    (valid)
    );

    // Binary search toward v: each trial adds the next lower power of two.
    task automatic build_model(input logic [W-1:0] v);
        int kept;
        int trial;
        kept = 0;
        for (int i = W - 1; i >= 0; i--) begin
            trial = kept + (1 << i);
            exp_seq[W-1-i] = trial[W-1:0];
            if (int'(v) >= trial) kept = trial;
        end
        exp_res = kept[W-1:0];
    endtask

    // Called at posedge+1 in an IDLE cycle; returns at posedge+1 in the IDLE cycle after done.
    task automatic run_conv(input logic [W-1:0] v, input bit spam, input bit abort_done, input string tag);
        int lat;
        int b;
        bit seen;
        build_model(v);
        vin   = v;
        abort = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 1;
        seen  = 1'b0;
        total_cnt++;
        if (valid !== 1'b0 || busy !== 1'b1) $display("FAIL %s accept: valid=%b busy=%b want 0/1", tag, valid, busy);
        else pass_cnt++;
        while (!seen && lat <= LAT + 5) begin
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (lat <= SMP) begin
                    total_cnt++;
                    if (sample !== 1'b1 || dac_code !== '0)
                        $display("FAIL %s sample c%0d: sample=%b dac=%h want 1/00", tag, lat, sample, dac_code);
                    else pass_cnt++;
                end else begin
                    b = (lat - SMP - 1) / HOLD;
                    if (b < W) begin
                        total_cnt++;
                        if (sample !== 1'b0 || dac_code !== exp_seq[b])
                            $display("FAIL %s trial c%0d: sample=%b dac=%h want 0/%h", tag, lat, sample, dac_code, exp_seq[b]);
                        else pass_cnt++;
                    end
                end
                if (spam) start = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                lat++;
            end
        end
        total_cnt++;
        if (!seen || lat != LAT) $display("FAIL %s latency: got %0d (seen=%b) want %0d", tag, lat, seen, LAT);
        else pass_cnt++;
        total_cnt++;
        if (result !== exp_res || valid !== 1'b1) $display("FAIL %s result: got %h v=%b want %h v=1", tag, result, valid, exp_res);
        else pass_cnt++;
        // a start or abort in the DONE cycle must have no effect
        start = spam;
        abort = abort_done;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b0 || valid !== 1'b1 || result !== exp_res)
            $display("FAIL %s after_done: done=%b busy=%b valid=%b res=%h want 0/0/1/%h", tag, done, busy, valid, result, exp_res);
        else pass_cnt++;
        last_res = exp_res;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        vin   = '0;
        #3;
        total_cnt++;
        if ({sample, dac_code, busy, done, result, valid} !== '0)
            $display("FAIL reset_outputs: s=%b dac=%h b=%b d=%b r=%h v=%b want all 0", sample, dac_code, busy, done, result, valid);
        else pass_cnt++;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (busy !== 1'b0 || valid !== 1'b0) $display("FAIL reset_idle: busy=%b valid=%b want 0/0", busy, valid);
        else pass_cnt++;
        last_res = '0;
    endtask

    task automatic test_known();
        run_conv(8'hA5, 1'b0, 1'b0, "conv_a5");
    endtask

    task automatic test_back_to_back();
        run_conv(8'h00, 1'b0, 1'b0, "b2b_00");
        run_conv(8'hFF, 1'b0, 1'b0, "b2b_ff");
    endtask

    task automatic test_start_ignored();
        run_conv(8'h3C, 1'b1, 1'b0, "busy_start");
    endtask

    task automatic test_abort(input int at_lat, input string tag);
        int dones;
        logic [W-1:0] prior;
        prior = last_res;
        vin   = W'($urandom_range(0, 255));
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < at_lat; c++) begin
            @(posedge clk); #1;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        total_cnt++;
        if (busy !== 1'b0 || sample !== 1'b0 || dac_code !== '0 || valid !== 1'b0 || done !== 1'b0 || result !== prior)
            $display("FAIL %s state: b=%b s=%b dac=%h v=%b d=%b r=%h want 0/0/00/0/0/%h",
                     tag, busy, sample, dac_code, valid, done, result, prior);
        else pass_cnt++;
        dones = 0;
        for (int c = 0; c < LAT + 2; c++) begin
            if (done === 1'b1 || busy === 1'b1) dones++;
            @(posedge clk); #1;
        end
        total_cnt++;
        if (dones != 0) $display("FAIL %s no_done: active cycles=%0d want 0", tag, dones);
        else pass_cnt++;
    endtask

    task automatic test_abort_idle();
        run_conv(8'h71, 1'b0, 1'b1, "abort_in_done");
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        total_cnt++;
        if (busy !== 1'b0 || sample !== 1'b0 || valid !== 1'b1 || result !== 8'h71)
            $display("FAIL abort_start_idle: b=%b s=%b v=%b r=%h want 0/0/1/71", busy, sample, valid, result);
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) run_conv(W'($urandom_range(0, 255)), 1'(n % 2), 1'b0, "rand_conv");
    endtask

    task automatic test_reset_mid();
        vin   = W'($urandom_range(0, 255));
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({sample, dac_code, busy, done, result, valid} !== '0)
            $display("FAIL reset_mid: s=%b dac=%h b=%b d=%b r=%h v=%b want all 0", sample, dac_code, busy, done, result, valid);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_mid_idle: busy=%b want 0", busy);
        else pass_cnt++;
        last_res = '0;
        run_conv(8'h5A, 1'b0, 1'b0, "post_reset_5a");
    endtask

    initial begin
        test_reset();
        test_known();
        test_back_to_back();
        test_start_ignored();
        run_conv(8'hA5, 1'b0, 1'b0, "prior_a5");
        test_abort(10, "abort_c10");
        test_abort($urandom_range(1, LAT - 1), "abort_rand");
        test_abort(1, "abort_c1");
        test_abort(LAT - 1, "abort_last");
        test_abort_idle();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
